vc_flow_receiver: RTL
=====================

# vc_flow_receiver

Receive end of the QoS virtual-channel push interface. Accepts 4-bit data words tagged with a 2-bit VC ID into four per-VC FIFOs. Per VC, raises Pause/Continue flow-control strobes from percentage occupancy thresholds and flags pushes into a full FIFO. Drains the FIFOs round-robin toward the downstream buffer on `Pop_buffer`.

## Interface
- `DEPTH`, 8: entries per VC FIFO; power of two, 4..64.
- `DW`, 4: data word width.
- `CLK` input 1: single clock, all logic on rising edge.
- `Reset` input 1: asynchronous, active-low reset.
- `Set_init` input 1: configuration phase. While high, thresholds are latched and push/pop are ignored.
- `Th_L` input 7: low threshold, percent of DEPTH.
- `Th_H` input 7: high threshold, percent of DEPTH.
- `Push_fifos` input 1: push request for the current `DataWord`/`VC_ID`.
- `VC_ID` input 2: target VC of the push.
- `DataWord` input DW: push data.
- `Pop_buffer` input 1: downstream requests one word.
- `Pause_stb` output 4: one-cycle pulse per VC on entering high occupancy.
- `Continue_stb` output 4: one-cycle pulse per VC on leaving pause at low occupancy.
- `Error_full` output 4: push attempted into a full VC FIFO.
- `Data_out` output DW: popped word.
- `VC_out` output 2: VC of the popped word.
- `Valid_out` output 1: `Data_out`/`VC_out` valid this cycle.
- `Idle` output 1: all four FIFOs empty.

## Operation
- Reset (async, `Reset`=0): all FIFO pointers and counts are 0; `paused[3:0]`=0; round-robin pointer is 3, so VC0 is served first; latched thresholds are 0.
  - Outputs at reset: `Pause_stb`=0, `Continue_stb`=0, `Error_full`=0, `Data_out`=0, `VC_out`=0, `Valid_out`=0, `Idle`=1.
- Config: each edge with `Set_init`=1 latches `thL<=Th_L`, `thH<=Th_H`. Push and pop are ignored during config.
- Push: on `Push_fifos`=1, write `DataWord` into FIFO[`VC_ID`] if `count<DEPTH`. Otherwise drop the word and raise the error.
- Pop: on `Pop_buffer`=1, with any FIFO non-empty, select the first non-empty VC scanning from `rr+1` (mod 4).
  - The selected head is registered to `Data_out`/`VC_out` with `Valid_out`=1, and `rr` becomes the served VC.
  - If all FIFOs are empty, `Valid_out`=0 and `Data_out`/`VC_out` hold their values.
- Occupancy compares use the next-state count `n` and 16-bit unsigned arithmetic.
  - hi: `n*100 >= thH*DEPTH`.
  - lo: `n*100 <= thL*DEPTH`.
- Flow control per VC v:
  - hi and not `paused[v]`: `Pause_stb[v]`=1, `paused[v]`<=1.
  - `paused[v]` and lo and not hi: `Continue_stb[v]`=1, `paused[v]`<=0.
  - hi takes priority, so with thL>=thH no Continue is ever issued while hi.
- Simultaneous push and pop on the same VC: count unchanged, both data moves performed.
- Push to a full VC is rejected even when that VC is popped in the same cycle.
- `Idle` = all next-state counts are 0, registered.

## Timing
- All outputs are registered.
- Push at edge k: the word is visible to pop at edge k+1. Strobes caused by a push at edge k are high during the cycle after edge k.
- Pop latency: `Pop_buffer` sampled at edge k gives `Valid_out` high after edge k, for one cycle. Back-to-back pops deliver one word per cycle.
- `Pause_stb`/`Continue_stb` are always single-cycle and never both high for the same VC.
- `Error_full` is a single-cycle pulse per rejected push in the default configuration.
- Reset assertion mid-transfer clears all state immediately. Words in the FIFOs are lost and no strobe is emitted.

## Configuration
- `ERROR_STICKY_EN` defined: `Error_full[v]` latches to 1 on the first rejected push. It clears only on `Reset` or on an edge with `Set_init`=1.
- `ERROR_STICKY_EN` undefined: `Error_full[v]` pulses for one cycle per rejected push.

## Test plan
All scenarios use DEPTH=8, Th_L=25, Th_H=75.
- Reset, `Set_init` high for 1 cycle, no traffic -> all strobes 0, `Idle`=1, `Valid_out`=0.
- 6 pushes to VC0 -> `Pause_stb`=4'b0001 for exactly one cycle after the 6th push; no pulse after pushes 1-5 or on a 7th push.
- From count 6 on VC0 with `paused[0]` set, pop 4 words -> `Continue_stb`=4'b0001 for one cycle after the 4th pop (count 2); VC0 outputs data in push order.
- 9 pushes to VC2 -> the 9th push gives `Error_full`=4'b0100. Without `ERROR_STICKY_EN` this is a one-cycle pulse; with `ERROR_STICKY_EN` it stays high until `Set_init`. FIFO holds the first 8 words.
- Push words 1,2,3,4 to VC0,VC1,VC2,VC3, then hold `Pop_buffer` high 5 cycles -> `VC_out` sequence 0,1,2,3 with data 1,2,3,4, then `Valid_out`=0 and `Idle`=1.
- Same-cycle push and pop on VC1 at count 3 -> count stays 3, popped word is the oldest, no strobes.

Source files
------------

// File: rtl/vc_flow_receiver.sv
// vc_flow_receiver: four per-VC FIFOs with occupancy flow-control strobes and round-robin drain.
// Define ERROR_STICKY_EN to make Error_full hold until Reset or a Set_init edge.
module vc_flow_receiver #(
  parameter int DEPTH = 8,
  parameter int DW = 4
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          Set_init,
  input  logic [6:0]    Th_L,
  input  logic [6:0]    Th_H,
  input  logic          Push_fifos,
  input  logic [1:0]    VC_ID,
  input  logic [DW-1:0] DataWord,
  input  logic          Pop_buffer,
  output logic [3:0]    Pause_stb,
  output logic [3:0]    Continue_stb,
  output logic [3:0]    Error_full,
  output logic [DW-1:0] Data_out,
  output logic [1:0]    VC_out,
  output logic          Valid_out,
  output logic          Idle
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem [4][DEPTH];
  logic [AW-1:0] wp [4];
  logic [AW-1:0] rp [4];
  logic [AW:0] cnt [4];
  logic [AW:0] nxt [4];
  logic [6:0] thl, thh;
  logic [3:0] paused, ne, push_ok, rej, pop_v, hi, lo, act, pst, cst;
  logic [1:0] rr, sel;
  logic any;
  // Push acceptance, round-robin pick, next-state counts and per-VC threshold decisions
  always_comb begin
    for (int v = 0; v < 4; v++) begin
      ne[v] = cnt[v] != '0;
      push_ok[v] = !Set_init && Push_fifos && VC_ID == 2'(v) && cnt[v] != (AW+1)'(DEPTH);
      rej[v] = !Set_init && Push_fifos && VC_ID == 2'(v) && cnt[v] == (AW+1)'(DEPTH);
    end
    sel = rr;
    any = 1'b0;
    for (int i = 4; i >= 1; i--)
      if (ne[rr + 2'(i)]) begin
        sel = rr + 2'(i);
        any = 1'b1;
      end
    for (int v = 0; v < 4; v++) begin
      pop_v[v] = !Set_init && Pop_buffer && any && sel == 2'(v);
      nxt[v] = cnt[v] + (AW+1)'(push_ok[v]) - (AW+1)'(pop_v[v]);
      hi[v] = 16'(nxt[v]) * 16'd100 >= 16'(thh) * 16'(DEPTH);
      lo[v] = 16'(nxt[v]) * 16'd100 <= 16'(thl) * 16'(DEPTH);
      act[v] = push_ok[v] | pop_v[v];
      pst[v] = act[v] && hi[v] && !paused[v];
      cst[v] = act[v] && paused[v] && lo[v] && !hi[v];
    end
  end
  // FIFO storage; contents need no reset since counts gate every read
  always_ff @(posedge CLK) begin
    for (int v = 0; v < 4; v++)
      if (push_ok[v]) mem[v][wp[v]] <= DataWord;
  end
  // Pointers, counts, pause state, thresholds and all registered outputs
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int v = 0; v < 4; v++) begin
        wp[v] <= '0;
        rp[v] <= '0;
        cnt[v] <= '0;
      end
      paused <= '0;
      rr <= 2'd3;
      thl <= '0;
      thh <= '0;
      Pause_stb <= '0;
      Continue_stb <= '0;
      Error_full <= '0;
      Data_out <= '0;
      VC_out <= '0;
      Valid_out <= 1'b0;
      Idle <= 1'b1;
    end else begin
      if (Set_init) begin
        thl <= Th_L;
        thh <= Th_H;
      end
      for (int v = 0; v < 4; v++) begin
        cnt[v] <= nxt[v];
        if (push_ok[v]) wp[v] <= wp[v] + AW'(1);
        if (pop_v[v]) rp[v] <= rp[v] + AW'(1);
      end
      paused <= (paused | pst) & ~cst;
      Pause_stb <= pst;
      Continue_stb <= cst;
      Valid_out <= |pop_v;
      if (|pop_v) begin
        Data_out <= mem[sel][rp[sel]];
        VC_out <= sel;
        rr <= sel;
      end
      Idle <= (nxt[0] | nxt[1] | nxt[2] | nxt[3]) == '0;
`ifdef ERROR_STICKY_EN
      Error_full <= Set_init ? '0 : Error_full | rej;
`else
      Error_full <= rej;
`endif
    end
  end
endmodule
